// File: rtl/sort_pkg.sv
// Shared types and helpers for the in-place exchange sort controller.
package sort_pkg;

  localparam int MAX_DATA_W = 64;

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CMP, WR_I, WR_J, NEXT, DONE
  } state_t;

  // Operands arrive zero-extended to MAX_DATA_W so one function serves every DATA_W.
  function automatic logic out_of_order(input logic [MAX_DATA_W-1:0] a,
                                        input logic [MAX_DATA_W-1:0] b,
                                        input logic dir);
    return dir ? (a < b) : (a > b);
  endfunction

  function automatic bit params_legal(input int data_w, input int depth,
                                      input int addr_w, input int rd_lat,
                                      input int wr_cyc);
    return (data_w >= 1) && (data_w <= MAX_DATA_W) &&
           (depth >= 2) && (depth <= 256) && (addr_w >= $clog2(depth)) &&
           (rd_lat >= 1) && (wr_cyc >= 1);
  endfunction

endpackage

// File: rtl/sort_ctrl_param.sv
// Exchange-sort controller for a single-port RAM with registered read:
// compares mem[i] against every later entry and swaps out-of-order pairs.
module sort_ctrl_param
  import sort_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 2,
  parameter int WR_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  descend,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [2*ADDR_W-1:0]   swap_count
);

  localparam int CNT_W = $clog2(((RD_LAT > WR_CYC) ? RD_LAT : WR_CYC) + 1);
  localparam logic [CNT_W-1:0]  RD_LAST = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0]  WR_LAST = CNT_W'(WR_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_J  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_I  = ADDR_W'(DEPTH - 2);

  if (!params_legal(DATA_W, DEPTH, ADDR_W, RD_LAT, WR_CYC)) begin : g_param_check
    $error("sort_ctrl_param: illegal parameter combination");
  end

  state_t              state, state_next;
  logic [ADDR_W-1:0]   i, j;
  logic [DATA_W-1:0]   a, b;
  logic [CNT_W-1:0]    cnt;
  logic                dir;
  logic                rd_last, wr_last, swap;

  assign rd_last = (cnt == RD_LAST);
  assign wr_last = (cnt == WR_LAST);
  assign swap    = out_of_order(MAX_DATA_W'(a), MAX_DATA_W'(b), dir);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RD_A;
      RD_A:    if (rd_last) state_next = RD_B;
      RD_B:    if (rd_last) state_next = CMP;
      CMP:     state_next = swap ? WR_I : NEXT;
      WR_I:    if (wr_last) state_next = WR_J;
      WR_J:    if (wr_last) state_next = NEXT;
      NEXT: begin
        if (j < LAST_J)      state_next = RD_B;
        else if (i < LAST_I) state_next = RD_A;
        else                 state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cnt only advances while dwelling in a timed state; any transition restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i          <= '0;
      j          <= ADDR_W'(1);
      a          <= '0;
      b          <= '0;
      cnt        <= '0;
      dir        <= 1'b0;
      swap_count <= '0;
    end else begin
      cnt <= (state_next == state && state != IDLE) ? cnt + 1'b1 : '0;
      case (state)
        IDLE: if (start) begin
          dir        <= descend;
          i          <= '0;
          j          <= ADDR_W'(1);
          swap_count <= '0;
        end
        RD_A: if (rd_last) a <= mem_rdata;
        RD_B: if (rd_last) b <= mem_rdata;
        WR_J: if (wr_last) begin
          a          <= b;
          swap_count <= swap_count + 1'b1;
        end
        NEXT: begin
          if (j < LAST_J) begin
            j <= j + 1'b1;
          end else if (i < LAST_I) begin
            i <= i + 1'b1;
            j <= i + ADDR_W'(2);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      RD_A: mem_addr = i;
      RD_B: mem_addr = j;
      WR_I: begin
        mem_addr  = i;
        mem_we    = 1'b1;
        mem_wdata = b;
      end
      WR_J: begin
        mem_addr  = j;
        mem_we    = 1'b1;
        mem_wdata = a;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/sort_ctrl_param.md
Name: sort_ctrl_param

Overview:
- In-place exchange sort of a DEPTH-entry, DATA_W-wide single-port memory, started by a one-cycle start request.
- Generalises the fixed 8x8 sort controller:
  - parametrised width, depth, read latency and write hold;
  - selectable ascending/descending order;
  - split read/write data buses instead of a tri-state bus;
  - busy flag and swap counter.
- Sits between the control/top level and a RAM with registered read.

Parameters:
- DATA_W, 8: element width in bits.
- DEPTH, 8: number of entries; legal range 2 to 256.
- ADDR_W, $clog2(DEPTH): address width.
- RD_LAT, 2: number of cycles from mem_addr stable to mem_rdata valid; must be 1 or more.
- WR_CYC, 2: number of cycles mem_we is held per write; must be 1 or more.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: sort request; sampled only in IDLE.
- descend, in, 1: 0 = ascending, 1 = descending; latched when start is accepted.
- mem_addr, out, ADDR_W: memory address.
- mem_we, out, 1: write enable, active high.
- mem_wdata, out, DATA_W: write data.
- mem_rdata, in, DATA_W: read data.
- busy, out, 1: high while sorting.
- done, out, 1: one-cycle completion pulse.
- swap_count, out, ADDR_W*2: number of swaps in the last or current run.

Behaviour:
- Reset values: all outputs 0. Internal state: FSM = IDLE, i = 0, j = 1, A = B = 0, cnt = 0, dir = 0.
- Algorithm, for i = 0 to DEPTH-2:
  - Read A = mem[i] once.
  - For j = i+1 to DEPTH-1: read B = mem[j].
  - If the pair is out of order, write mem[i] = B, then mem[j] = A, then set A <= B.
  - Out of order means A > B when ascending, A < B when descending. Equal values never swap.
- FSM states: IDLE, RD_A, RD_B, CMP, WR_I, WR_J, NEXT, DONE. All outputs are registered or decoded from the state (Moore).
- IDLE: if start, latch dir <= descend, set i = 0, j = 1, clear swap_count, go to RD_A.
- RD_A and RD_B:
  - mem_addr = i (RD_A) or j (RD_B); cnt counts from 0.
  - The state lasts RD_LAT+1 cycles. On the last cycle, mem_rdata is captured into A or B.
  - RD_A goes to RD_B; RD_B goes to CMP.
- CMP (1 cycle): if out of order, go to WR_I; otherwise go to NEXT.
- WR_I:
  - mem_addr = i, mem_wdata = B, mem_we = 1, held for WR_CYC cycles. Then go to WR_J.
- WR_J:
  - mem_addr = j, mem_wdata = A, mem_we = 1, held for WR_CYC cycles.
  - On exit, A <= B and swap_count increments. Then go to NEXT.
- NEXT (1 cycle):
  - If j < DEPTH-1: j <= j+1, go to RD_B.
  - Else if i < DEPTH-2: i <= i+1, j <= i+2, go to RD_A.
  - Else go to DONE.
- DONE (1 cycle): done = 1, then go to IDLE. swap_count holds its value until the next accepted start.
- busy = 1 in every state except IDLE and DONE.
- mem_we = 1 only in WR_I and WR_J. mem_addr = 0 and mem_wdata = 0 in IDLE and DONE.
- cnt width is $clog2(max(RD_LAT, WR_CYC)+1). cnt clears on every state change.
- Busy duration for a run is (DEPTH-1)*(RD_LAT+1) + P*(RD_LAT+3) + S*2*WR_CYC cycles, where P = DEPTH*(DEPTH-1)/2 and S = number of swaps.
- Boundaries:
  - start while busy or in DONE: ignored; no queueing.
  - Changing descend mid-run: no effect.
  - DEPTH = 2: exactly one compare.
  - Counters must not wrap: i, j and swap_count are sized for the maximum values.
  - rst mid-run: immediate return to reset values. Memory is left partially sorted, but never mid-write after rst deasserts, because mem_we drops asynchronously.

Decomposition:
- Shared package sort_pkg:
  - FSM state enum;
  - function for the order compare (a, b, dir) returning out_of_order;
  - parameter legality checks.
- No sub-module needed. The wait counter stays inline.

Test Plan:
- Already sorted 1..8, ascending, default parameters:
  - no mem_we ever asserted;
  - swap_count = 0;
  - busy high for exactly 161 cycles, then done for 1 cycle.
- DEPTH=4, memory [4,3,2,1], ascending:
  - final memory [1,2,3,4];
  - swap_count = 6;
  - busy high for 63 cycles.
- DEPTH=4, memory [1,2,3,4], descend=1:
  - final memory [4,3,2,1];
  - swap_count = 6.
- Memory [5,5,5,5,5,5,5,5]: no writes; swap_count = 0. Proves equal values never swap.
- Random 8x8 data with start pulsed again mid-run and descend toggled mid-run:
  - the second start is ignored and the result follows the latched direction;
  - final memory matches the reference model.
- rst asserted in WR_I during a swap:
  - all outputs 0 in the same cycle, with mem_we low;
  - a subsequent start sorts the data fully.
